// File: rtl/spec_issue_queue_if.sv
// Enqueue/issue handshake bundle for the speculative issue queue.
// slave = queue side, master = decode/FU side.
interface spec_issue_queue_if #(
    parameter int INST_ID_BIT    = 8,
    parameter int REG_ID_BIT     = 3,
    parameter int IMM_BIT        = 4,
    parameter int SPEC_LEVEL_BIT = 3
);
    logic                      in_vld;
    logic                      in_rdy;
    logic [INST_ID_BIT-1:0]    in_id;
    logic [REG_ID_BIT-1:0]     in_dst_reg;
    logic [REG_ID_BIT-1:0]     in_src_reg0;
    logic [REG_ID_BIT-1:0]     in_src_reg1;
    logic [IMM_BIT-1:0]        in_imm;
    logic [SPEC_LEVEL_BIT-1:0] in_spec_level;

    logic                      out_vld;
    logic                      out_rdy;
    logic [INST_ID_BIT-1:0]    out_id;
    logic [REG_ID_BIT-1:0]     out_dst_reg;
    logic [REG_ID_BIT-1:0]     out_src_reg0;
    logic [REG_ID_BIT-1:0]     out_src_reg1;
    logic [IMM_BIT-1:0]        out_imm;
    logic [SPEC_LEVEL_BIT-1:0] out_spec_level;

    modport slave (
        input  in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1,
               in_imm, in_spec_level, out_rdy,
        output in_rdy, out_vld, out_id, out_dst_reg, out_src_reg0,
               out_src_reg1, out_imm, out_spec_level
    );

    modport master (
        output in_vld, in_id, in_dst_reg, in_src_reg0, in_src_reg1,
               in_imm, in_spec_level, out_rdy,
        input  in_rdy, out_vld, out_id, out_dst_reg, out_src_reg0,
               out_src_reg1, out_imm, out_spec_level
    );
endinterface

// File: rtl/spec_issue_queue.sv
// In-order speculative issue queue: bulk tail-rewind squash,
// level remap on branch success, per-register pending-read counts.
module spec_issue_queue #(
    parameter int FIFO_SIZE      = 8,
    parameter int INST_ID_BIT    = 8,
    parameter int NUM_REG        = 8,
    parameter int IMM_BIT        = 4,
    parameter int SPEC_DEPTH     = 4,
    parameter int REG_ID_BIT     = $clog2(NUM_REG),
    parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
    parameter int CNT_BIT        = $clog2(2 * FIFO_SIZE + 1),
    parameter int PTR_BIT        = $clog2(FIFO_SIZE)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    spec_issue_queue_if.slave                          io,
    input  logic                                       br_pred_vld,
    output logic                                       br_pred_rdy,
    input  logic                                       br_pred_succ,
    input  logic [SPEC_LEVEL_BIT-1:0]                  br_pred_fail_level,
    input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]   br_pred_succ_nxt_levels,
    output logic [PTR_BIT:0]                           count,
    output logic                                       empty,
    output logic [NUM_REG-1:0]                         pending_read,
    output logic [NUM_REG*CNT_BIT-1:0]                 pending_read_cnt
);

    typedef struct packed {
        logic [INST_ID_BIT-1:0]    id;
        logic [REG_ID_BIT-1:0]     dst;
        logic [REG_ID_BIT-1:0]     src0;
        logic [REG_ID_BIT-1:0]     src1;
        logic [IMM_BIT-1:0]        imm;
        logic [SPEC_LEVEL_BIT-1:0] lvl;
    } ent_t;

    ent_t                mem_q [FIFO_SIZE];
    ent_t                mem_d [FIFO_SIZE];
    logic [PTR_BIT-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_BIT-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BIT:0]    cnt_q, cnt_d;

    logic [FIFO_SIZE-1:0] valid;
    logic                 fail, succ_ev, push, pop, found;
    logic [PTR_BIT-1:0]   k_off;
    ent_t                 head;
    logic [CNT_BIT-1:0]   pc [NUM_REG];

    // Levels outside the table range pass through unchanged.
    function automatic logic [SPEC_LEVEL_BIT-1:0] remap(
        input logic [SPEC_LEVEL_BIT-1:0]                lvl,
        input logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] tbl
    );
        logic [SPEC_LEVEL_BIT-1:0] r;
        r = lvl;
        for (int l = 0; l <= SPEC_DEPTH; l++) begin
            if (lvl == SPEC_LEVEL_BIT'(l)) begin
                r = tbl[l*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
            end
        end
        return r;
    endfunction

    assign fail    = br_pred_vld && !br_pred_succ;
    assign succ_ev = br_pred_vld && br_pred_succ;
    assign head    = mem_q[rd_ptr_q];

    assign count       = cnt_q;
    assign empty       = (cnt_q == '0);
    assign br_pred_rdy = 1'b1;

    assign io.in_rdy = (cnt_q < (PTR_BIT+1)'(FIFO_SIZE)) && !fail;
    assign io.out_vld = !empty &&
                        !(fail && (head.lvl >= br_pred_fail_level));

    assign io.out_id         = head.id;
    assign io.out_dst_reg    = head.dst;
    assign io.out_src_reg0   = head.src0;
    assign io.out_src_reg1   = head.src1;
    assign io.out_imm        = head.imm;
    assign io.out_spec_level = succ_ev ?
                               remap(head.lvl, br_pred_succ_nxt_levels) :
                               head.lvl;

    assign push = io.in_vld && io.in_rdy;
    assign pop  = io.out_vld && io.out_rdy;

    // Slot validity from head-relative offset vs occupancy.
    always_comb begin
        valid = '0;
        for (int i = 0; i < FIFO_SIZE; i++) begin
            valid[i] = {1'b0, PTR_BIT'(PTR_BIT'(i) - rd_ptr_q)} < cnt_q;
        end
    end

    // Find the oldest entry at or above the failing level.
    always_comb begin
        logic [PTR_BIT-1:0] idx;
        found = 1'b0;
        k_off = '0;
        idx   = '0;
        for (int j = 0; j < FIFO_SIZE; j++) begin
            idx = rd_ptr_q + PTR_BIT'(j);
            if (!found && ((PTR_BIT+1)'(j) < cnt_q) &&
                (mem_q[idx].lvl >= br_pred_fail_level)) begin
                found = 1'b1;
                k_off = PTR_BIT'(j);
            end
        end
    end

    // Next-state: remap, enqueue, pop and squash rewind.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (succ_ev) begin
            for (int i = 0; i < FIFO_SIZE; i++) begin
                if (valid[i]) begin
                    mem_d[i].lvl = remap(mem_q[i].lvl,
                                         br_pred_succ_nxt_levels);
                end
            end
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{id:   io.in_id,
                                dst:  io.in_dst_reg,
                                src0: io.in_src_reg0,
                                src1: io.in_src_reg1,
                                imm:  io.in_imm,
                                lvl:  io.in_spec_level};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BIT'(1);
        end
        if (fail && found) begin
            wr_ptr_d = rd_ptr_q + k_off;
            cnt_d    = {1'b0, k_off} - (PTR_BIT+1)'(pop);
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_BIT'(push);
            cnt_d    = cnt_q + (PTR_BIT+1)'(push) - (PTR_BIT+1)'(pop);
        end
    end

    // Source-operand counts over currently valid entries.
    always_comb begin
        for (int r = 0; r < NUM_REG; r++) begin
            pc[r] = '0;
        end
        for (int i = 0; i < FIFO_SIZE; i++) begin
            if (valid[i] && (mem_q[i].src0 != '0)) begin
                pc[mem_q[i].src0] = pc[mem_q[i].src0] + CNT_BIT'(1);
            end
            if (valid[i] && (mem_q[i].src1 != '0)) begin
                pc[mem_q[i].src1] = pc[mem_q[i].src1] + CNT_BIT'(1);
            end
        end
    end

    for (genvar r = 0; r < NUM_REG; r++) begin : g_pend
        assign pending_read_cnt[r*CNT_BIT +: CNT_BIT] = pc[r];
        assign pending_read[r] = (pc[r] != '0);
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < FIFO_SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_spec_issue_queue.sv
// Scoreboard bench for spec_issue_queue: directed stimulus pushes
// expected issues; a negedge monitor pops and compares.
module tb_spec_issue_queue;

    localparam int SLB = 3;
    localparam int CB  = 5;

    typedef struct packed {
        logic [7:0] id;
        logic [2:0] dst;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [3:0] imm;
        logic [2:0] lvl;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic br_pred_vld = 1'b0;
    logic br_pred_rdy;
    logic br_pred_succ = 1'b0;
    logic [SLB-1:0] br_pred_fail_level = '0;
    logic [SLB*5-1:0] br_pred_succ_nxt_levels = '0;
    logic [3:0] count;
    logic empty;
    logic [7:0] pending_read;
    logic [8*CB-1:0] pending_read_cnt;

    int checks = 0;
    int errors = 0;
    ent_t exp_q[$];
    ent_t mon_e;
    bit acc;

    spec_issue_queue_if io ();

    spec_issue_queue dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .io                      (io.slave),
        .br_pred_vld             (br_pred_vld),
        .br_pred_rdy             (br_pred_rdy),
        .br_pred_succ            (br_pred_succ),
        .br_pred_fail_level      (br_pred_fail_level),
        .br_pred_succ_nxt_levels (br_pred_succ_nxt_levels),
        .count                   (count),
        .empty                   (empty),
        .pending_read            (pending_read),
        .pending_read_cnt        (pending_read_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && io.out_vld && io.out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_spurious: got id %0h expected none",
                         io.out_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue",
                    {8'h0, io.out_id, io.out_dst_reg, io.out_src_reg0,
                     io.out_src_reg1, io.out_imm, io.out_spec_level},
                    {8'h0, mon_e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] id, input logic [2:0] d,
                        input logic [2:0] s0, input logic [2:0] s1,
                        input logic [3:0] imm, input logic [2:0] lvl,
                        output bit ok);
        io.in_id = id;
        io.in_dst_reg = d;
        io.in_src_reg0 = s0;
        io.in_src_reg1 = s1;
        io.in_imm = imm;
        io.in_spec_level = lvl;
        io.in_vld = 1'b1;
        #1;
        ok = io.in_rdy;
        if (ok) exp_q.push_back('{id, d, s0, s1, imm, lvl});
        @(posedge clk);
        #1;
        io.in_vld = 1'b0;
    endtask

    task automatic drain(input int n);
        io.out_rdy = 1'b1;
        repeat (n) cyc();
        io.out_rdy = 1'b0;
    endtask

    task automatic squash_model(input logic [2:0] lvl);
        int k;
        k = exp_q.size();
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].lvl >= lvl) k = i;
        end
        while (exp_q.size() > k) void'(exp_q.pop_back());
    endtask

    task automatic burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            io.in_id = base + 8'(i);
            io.in_dst_reg = 3'(i);
            io.in_src_reg0 = 3'((i % 7) + 1);
            io.in_src_reg1 = 3'd0;
            io.in_imm = 4'(i);
            io.in_spec_level = 3'd0;
            io.in_vld = 1'b1;
            io.out_rdy = 1'b1;
            #1;
            chk("burst_rdy", 32'(io.in_rdy), 32'd1);
            if (io.in_rdy)
                exp_q.push_back('{io.in_id, io.in_dst_reg, io.in_src_reg0,
                                  3'd0, io.in_imm, 3'd0});
            @(posedge clk);
            #1;
        end
        io.in_vld = 1'b0;
        io.out_rdy = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_vld"}, 32'(io.out_vld), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_in_rdy"}, 32'(io.in_rdy), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_pend"}, 32'(pending_read), 32'd0);
        chk({tag, "_pend_cnt"}, pending_read_cnt[31:0], 32'd0);
    endtask

    initial begin
        io.in_vld = 1'b0;
        io.out_rdy = 1'b0;
        io.in_id = '0;
        io.in_dst_reg = '0;
        io.in_src_reg0 = '0;
        io.in_src_reg1 = '0;
        io.in_imm = '0;
        io.in_spec_level = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        reset_checks("reset");
        chk("br_rdy", 32'(br_pred_rdy), 32'd1);
        cyc();

        // Fill to capacity, reject the ninth, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), 3'(i % 8), 3'd0, 3'd0, 4'(i), 3'd0, acc);
            chk("fill_acc", 32'(acc), 32'd1);
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_in_rdy", 32'(io.in_rdy), 32'd0);
        push(8'd9, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0, acc);
        chk("full_reject", 32'(acc), 32'd0);
        drain(8);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_out_vld", 32'(io.out_vld), 32'd0);

        // Pending-read counters.
        push(8'h11, 3'd1, 3'd3, 3'd3, 4'd1, 3'd0, acc);
        push(8'h12, 3'd2, 3'd3, 3'd5, 4'd2, 3'd0, acc);
        push(8'h13, 3'd4, 3'd0, 3'd2, 4'd3, 3'd0, acc);
        chk("pend_r3", 32'(pending_read_cnt[3*CB +: CB]), 32'd3);
        chk("pend_r5", 32'(pending_read_cnt[5*CB +: CB]), 32'd1);
        chk("pend_r2", 32'(pending_read_cnt[2*CB +: CB]), 32'd1);
        chk("pend_r0", 32'(pending_read_cnt[0 +: CB]), 32'd0);
        chk("pend_vec", 32'(pending_read), 32'h2c);
        drain(3);
        chk("pend_cleared", 32'(pending_read), 32'd0);

        // Tail squash at level 1, then immediate refill.
        push(8'h20, 3'd1, 3'd1, 3'd0, 4'd0, 3'd0, acc);
        push(8'h21, 3'd1, 3'd0, 3'd0, 4'd1, 3'd0, acc);
        push(8'h22, 3'd1, 3'd6, 3'd0, 4'd2, 3'd1, acc);
        push(8'h23, 3'd1, 3'd7, 3'd0, 4'd3, 3'd2, acc);
        push(8'h24, 3'd1, 3'd7, 3'd0, 4'd4, 3'd2, acc);
        br_pred_vld = 1'b1;
        br_pred_succ = 1'b0;
        br_pred_fail_level = 3'd1;
        #1;
        chk("fail_in_rdy", 32'(io.in_rdy), 32'd0);
        squash_model(3'd1);
        cyc();
        br_pred_vld = 1'b0;
        chk("squash_count", 32'(count), 32'd2);
        chk("squash_pend", 32'(pending_read), 32'h02);
        for (int i = 0; i < 3; i++) begin
            push(8'h30 + 8'(i), 3'd2, 3'd0, 3'd0, 4'(i), 3'd0, acc);
            chk("refill_acc", 32'(acc), 32'd1);
        end
        chk("refill_count", 32'(count), 32'd5);
        drain(5);

        // Squash behind a head that pops the same cycle.
        push(8'h40, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0, acc);
        push(8'h41, 3'd1, 3'd0, 3'd0, 4'd0, 3'd1, acc);
        io.out_rdy = 1'b1;
        br_pred_vld = 1'b1;
        br_pred_fail_level = 3'd1;
        #1;
        chk("popsq_out_vld", 32'(io.out_vld), 32'd1);
        squash_model(3'd1);
        cyc();
        br_pred_vld = 1'b0;
        io.out_rdy = 1'b0;
        chk("popsq_count", 32'(count), 32'd0);

        // Squashed head is never issued.
        push(8'h50, 3'd1, 3'd4, 3'd0, 4'd0, 3'd1, acc);
        io.out_rdy = 1'b1;
        br_pred_vld = 1'b1;
        br_pred_fail_level = 3'd1;
        #1;
        chk("headsq_out_vld", 32'(io.out_vld), 32'd0);
        squash_model(3'd1);
        cyc();
        br_pred_vld = 1'b0;
        io.out_rdy = 1'b0;
        chk("headsq_empty", 32'(empty), 32'd1);
        chk("headsq_count", 32'(count), 32'd0);

        // Success remap 1->0, 2->1, with a same-cycle enqueue.
        push(8'h60, 3'd1, 3'd0, 3'd0, 4'd0, 3'd1, acc);
        push(8'h61, 3'd2, 3'd0, 3'd0, 4'd1, 3'd2, acc);
        br_pred_succ_nxt_levels = {3'd4, 3'd3, 3'd1, 3'd0, 3'd0};
        br_pred_succ = 1'b1;
        br_pred_vld = 1'b1;
        io.in_id = 8'h62;
        io.in_dst_reg = 3'd3;
        io.in_src_reg0 = 3'd0;
        io.in_src_reg1 = 3'd0;
        io.in_imm = 4'd2;
        io.in_spec_level = 3'd2;
        io.in_vld = 1'b1;
        #1;
        chk("succ_lvl_now", 32'(io.out_spec_level), 32'd0);
        chk("succ_in_rdy", 32'(io.in_rdy), 32'd1);
        foreach (exp_q[i]) begin
            if (exp_q[i].lvl == 3'd1) exp_q[i].lvl = 3'd0;
            else if (exp_q[i].lvl == 3'd2) exp_q[i].lvl = 3'd1;
        end
        if (io.in_rdy) exp_q.push_back('{8'h62, 3'd3, 3'd0, 3'd0, 4'd2, 3'd2});
        cyc();
        io.in_vld = 1'b0;
        br_pred_vld = 1'b0;
        br_pred_succ = 1'b0;
        chk("succ_lvl_stored", 32'(io.out_spec_level), 32'd0);
        chk("succ_count", 32'(count), 32'd3);
        drain(3);

        // Pointer wrap at occupancy 7, then reset mid-burst.
        for (int i = 0; i < 7; i++)
            push(8'h70 + 8'(i), 3'd1, 3'd1, 3'd0, 4'(i), 3'd0, acc);
        burst(20, 8'h80);
        chk("wrap_count", 32'(count), 32'd7);
        burst(3, 8'hA0);
        io.in_vld = 1'b1;
        io.out_rdy = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        reset_checks("midrst");
        io.in_vld = 1'b0;
        io.out_rdy = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        reset_checks("post_rst");

        push(8'hC0, 3'd5, 3'd6, 3'd0, 4'd9, 3'd0, acc);
        chk("post_count", 32'(count), 32'd1);
        drain(1);
        chk("leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
